// File: rtl/ex_mem_dual_reg_pkg.sv
// Shared definitions for the dual-issue EX/MEM pipeline register.
// Holds the update-operation encoding and the codebase's common constants.
package ex_mem_dual_reg_pkg;

    localparam logic RstEnable      = 1'b1;
    localparam logic WriteEnable    = 1'b1;
    localparam logic WriteDisable   = 1'b0;
    localparam logic OverflowAssert = 1'b1;

    localparam int RegBusW     = 32;
    localparam int RegAddrBusW = 5;
    localparam int InstAddrW   = 32;
    localparam int OvfBit      = 12;

    localparam logic [InstAddrW-1:0] ZeroWord = '0;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'd0,
        OP_BUBBLE = 2'd1,
        OP_HOLD   = 2'd2,
        OP_CLEAR  = 2'd3
    } upd_op_e;

    // Flush outranks every stall combination; reset is handled by the registers.
    function automatic upd_op_e decode_op(input logic flush,
                                          input logic stall_ex,
                                          input logic stall_mem);
        if (flush)
            return OP_CLEAR;
        else if (stall_ex && !stall_mem)
            return OP_BUBBLE;
        else if (stall_ex)
            return OP_HOLD;
        else
            return OP_LOAD;
    endfunction

endpackage

// File: rtl/ex_mem_slot_reg.sv
// One issue slot of the EX/MEM register: load / bubble / hold / clear.
// kill_i turns a load into a dead entry that keeps pc/waddr/wdata for debug.
module ex_mem_slot_reg
    import ex_mem_dual_reg_pkg::*;
#(
    parameter int DATA_W = RegBusW,
    parameter int ADDR_W = RegAddrBusW,
    parameter int EXC_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  upd_op_e              op_i,
    input  logic                 kill_i,
    input  logic                 valid_i,
    input  logic [InstAddrW-1:0] pc_i,
    input  logic [ADDR_W-1:0]    waddr_i,
    input  logic                 we_i,
    input  logic [DATA_W-1:0]    wdata_i,
    input  logic                 whilo_i,
    input  logic [DATA_W-1:0]    hi_i,
    input  logic [DATA_W-1:0]    lo_i,
    input  logic [EXC_W-1:0]     exc_i,
    output logic                 valid_o,
    output logic [InstAddrW-1:0] pc_o,
    output logic [ADDR_W-1:0]    waddr_o,
    output logic                 we_o,
    output logic [DATA_W-1:0]    wdata_o,
    output logic                 whilo_o,
    output logic [DATA_W-1:0]    hi_o,
    output logic [DATA_W-1:0]    lo_o,
    output logic [EXC_W-1:0]     exc_o,
    output logic                 killed_o
);

    logic                 valid_q,  valid_d;
    logic [InstAddrW-1:0] pc_q,     pc_d;
    logic [ADDR_W-1:0]    waddr_q,  waddr_d;
    logic                 we_q,     we_d;
    logic [DATA_W-1:0]    wdata_q,  wdata_d;
    logic                 whilo_q,  whilo_d;
    logic [DATA_W-1:0]    hi_q,     hi_d;
    logic [DATA_W-1:0]    lo_q,     lo_d;
    logic [EXC_W-1:0]     exc_q,    exc_d;
    logic                 killed_q, killed_d;

    always_comb begin
        valid_d  = valid_q;
        pc_d     = pc_q;
        waddr_d  = waddr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        whilo_d  = whilo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        exc_d    = exc_q;
        killed_d = killed_q;
        case (op_i)
            OP_CLEAR, OP_BUBBLE: begin
                valid_d  = 1'b0;
                pc_d     = ZeroWord;
                waddr_d  = '0;
                we_d     = WriteDisable;
                wdata_d  = '0;
                whilo_d  = 1'b0;
                hi_d     = '0;
                lo_d     = '0;
                exc_d    = '0;
                killed_d = 1'b0;
            end
            OP_LOAD: begin
                pc_d    = pc_i;
                waddr_d = waddr_i;
                wdata_d = wdata_i;
                hi_d    = hi_i;
                lo_d    = lo_i;
                if (kill_i) begin
                    valid_d  = 1'b0;
                    we_d     = WriteDisable;
                    whilo_d  = 1'b0;
                    exc_d    = '0;
                    killed_d = 1'b1;
                end else begin
                    valid_d  = valid_i;
                    we_d     = we_i;
                    whilo_d  = whilo_i;
                    exc_d    = exc_i;
                    killed_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            valid_q  <= 1'b0;
            pc_q     <= ZeroWord;
            waddr_q  <= '0;
            we_q     <= WriteDisable;
            wdata_q  <= '0;
            whilo_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            exc_q    <= '0;
            killed_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            waddr_q  <= waddr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            whilo_q  <= whilo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            exc_q    <= exc_d;
            killed_q <= killed_d;
        end
    end

    assign valid_o  = valid_q;
    assign pc_o     = pc_q;
    assign waddr_o  = waddr_q;
    assign we_o     = we_q;
    assign wdata_o  = wdata_q;
    assign whilo_o  = whilo_q;
    assign hi_o     = hi_q;
    assign lo_o     = lo_q;
    assign exc_o    = exc_q;
    assign killed_o = killed_q;

endmodule

// File: rtl/ex_mem_dual_reg.sv
// EX->MEM pipeline register for the dual-issue core with precise cross-slot exceptions.
// Optional EX_MEM_STALL_CNT_EN adds a saturating EX-stall cycle counter (stall_cnt_o).
module ex_mem_dual_reg
    import ex_mem_dual_reg_pkg::*;
#(
    parameter int DATA_W = RegBusW,
    parameter int ADDR_W = RegAddrBusW,
    parameter int EXC_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_ex,
    input  logic                 stall_mem,
    input  logic                 flush,
    input  logic                 s1_valid_i,
    input  logic                 s2_valid_i,
    input  logic [InstAddrW-1:0] s1_pc_i,
    input  logic [InstAddrW-1:0] s2_pc_i,
    input  logic [ADDR_W-1:0]    s1_waddr_i,
    input  logic [ADDR_W-1:0]    s2_waddr_i,
    input  logic                 s1_we_i,
    input  logic                 s2_we_i,
    input  logic [DATA_W-1:0]    s1_wdata_i,
    input  logic [DATA_W-1:0]    s2_wdata_i,
    input  logic                 s1_whilo_i,
    input  logic                 s2_whilo_i,
    input  logic [DATA_W-1:0]    s1_hi_i,
    input  logic [DATA_W-1:0]    s1_lo_i,
    input  logic [DATA_W-1:0]    s2_hi_i,
    input  logic [DATA_W-1:0]    s2_lo_i,
    input  logic [EXC_W-1:0]     s1_exc_i,
    input  logic [EXC_W-1:0]     s2_exc_i,
    output logic                 s1_valid_o,
    output logic [InstAddrW-1:0] s1_pc_o,
    output logic [ADDR_W-1:0]    s1_waddr_o,
    output logic                 s1_we_o,
    output logic [DATA_W-1:0]    s1_wdata_o,
    output logic [EXC_W-1:0]     s1_exc_o,
    output logic                 s2_valid_o,
    output logic [InstAddrW-1:0] s2_pc_o,
    output logic [ADDR_W-1:0]    s2_waddr_o,
    output logic                 s2_we_o,
    output logic [DATA_W-1:0]    s2_wdata_o,
    output logic [EXC_W-1:0]     s2_exc_o,
    output logic                 whilo_o,
    output logic [DATA_W-1:0]    hi_o,
    output logic [DATA_W-1:0]    lo_o,
    output logic                 s2_squashed_o
`ifdef EX_MEM_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cnt_o
`endif
);

    upd_op_e     op;
    logic        squash;
    logic        s1_we_gated, s2_we_gated;
    logic        s1_whilo_gated, s2_whilo_gated;
    logic        s1_whilo_q, s2_whilo_q;
    logic [DATA_W-1:0] s1_hi_q, s1_lo_q, s2_hi_q, s2_lo_q;
    logic        s1_killed;

    assign op = decode_op(flush, stall_ex, stall_mem);

    // A faulting slot-1 instruction is older, so slot 2 must not retire.
    assign squash = s1_valid_i && (|s1_exc_i);

    assign s1_we_gated    = (s1_we_i == WriteEnable && s1_valid_i) ? WriteEnable : WriteDisable;
    assign s2_we_gated    = (s2_we_i == WriteEnable && s2_valid_i) ? WriteEnable : WriteDisable;
    assign s1_whilo_gated = s1_whilo_i && s1_valid_i;
    assign s2_whilo_gated = s2_whilo_i && s2_valid_i;

    ex_mem_slot_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .EXC_W(EXC_W)) u_slot1 (
        .clk      (clk),
        .rst      (rst),
        .op_i     (op),
        .kill_i   (1'b0),
        .valid_i  (s1_valid_i),
        .pc_i     (s1_pc_i),
        .waddr_i  (s1_waddr_i),
        .we_i     (s1_we_gated),
        .wdata_i  (s1_wdata_i),
        .whilo_i  (s1_whilo_gated),
        .hi_i     (s1_hi_i),
        .lo_i     (s1_lo_i),
        .exc_i    (s1_exc_i),
        .valid_o  (s1_valid_o),
        .pc_o     (s1_pc_o),
        .waddr_o  (s1_waddr_o),
        .we_o     (s1_we_o),
        .wdata_o  (s1_wdata_o),
        .whilo_o  (s1_whilo_q),
        .hi_o     (s1_hi_q),
        .lo_o     (s1_lo_q),
        .exc_o    (s1_exc_o),
        .killed_o (s1_killed)
    );

    ex_mem_slot_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .EXC_W(EXC_W)) u_slot2 (
        .clk      (clk),
        .rst      (rst),
        .op_i     (op),
        .kill_i   (squash),
        .valid_i  (s2_valid_i),
        .pc_i     (s2_pc_i),
        .waddr_i  (s2_waddr_i),
        .we_i     (s2_we_gated),
        .wdata_i  (s2_wdata_i),
        .whilo_i  (s2_whilo_gated),
        .hi_i     (s2_hi_i),
        .lo_i     (s2_lo_i),
        .exc_i    (s2_exc_i),
        .valid_o  (s2_valid_o),
        .pc_o     (s2_pc_o),
        .waddr_o  (s2_waddr_o),
        .we_o     (s2_we_o),
        .wdata_o  (s2_wdata_o),
        .whilo_o  (s2_whilo_q),
        .hi_o     (s2_hi_q),
        .lo_o     (s2_lo_q),
        .exc_o    (s2_exc_o),
        .killed_o (s2_squashed_o)
    );

    // Slot 2 is later in program order, so its HI/LO write is the one that survives.
    always_comb begin
        whilo_o = 1'b0;
        hi_o    = '0;
        lo_o    = '0;
        if (s2_whilo_q) begin
            whilo_o = 1'b1;
            hi_o    = s2_hi_q;
            lo_o    = s2_lo_q;
        end else if (s1_whilo_q) begin
            whilo_o = 1'b1;
            hi_o    = s1_hi_q;
            lo_o    = s1_lo_q;
        end
    end

`ifdef EX_MEM_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_ex && !flush && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

    ap_s2_needs_s1: assert property (@(posedge clk) disable iff (rst)
        (!stall_ex && !flush && s2_valid_i) |-> s1_valid_i);

    // Overflowing adds/subs must already have their write enable dropped upstream.
    ap_s1_ovf_no_we: assert property (@(posedge clk) disable iff (rst)
        (!stall_ex && !flush && s1_valid_i && s1_exc_i[OvfBit] == OverflowAssert) |-> !s1_we_i);
    ap_s2_ovf_no_we: assert property (@(posedge clk) disable iff (rst)
        (!stall_ex && !flush && s2_valid_i && s2_exc_i[OvfBit] == OverflowAssert) |-> !s2_we_i);

    ap_slot1_never_killed: assert property (@(posedge clk) !s1_killed);

endmodule

// File: tb/tb_ex_mem_dual_reg.sv
// Self-checking bench for ex_mem_dual_reg: directed scenarios plus randomized traffic
// compared against a transaction-level model of the register's update rules.
module tb_ex_mem_dual_reg;

    typedef struct packed {
        logic        s1v;
        logic [31:0] s1pc;
        logic [4:0]  s1wa;
        logic        s1we;
        logic [31:0] s1wd;
        logic        s1wh;
        logic [31:0] s1hi;
        logic [31:0] s1lo;
        logic [31:0] s1exc;
        logic        s2v;
        logic [31:0] s2pc;
        logic [4:0]  s2wa;
        logic        s2we;
        logic [31:0] s2wd;
        logic        s2wh;
        logic [31:0] s2hi;
        logic [31:0] s2lo;
        logic [31:0] s2exc;
    } in_t;

    typedef struct packed {
        logic        s1v;
        logic [31:0] s1pc;
        logic [4:0]  s1wa;
        logic        s1we;
        logic [31:0] s1wd;
        logic [31:0] s1exc;
        logic        s2v;
        logic [31:0] s2pc;
        logic [4:0]  s2wa;
        logic        s2we;
        logic [31:0] s2wd;
        logic [31:0] s2exc;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        sq;
    } obs_t;

    logic clk = 1'b0;
    logic rst, stall_ex, stall_mem, flush;
    in_t  cur;

    logic        s1_valid_o, s2_valid_o, s1_we_o, s2_we_o, whilo_o, s2_squashed_o;
    logic [31:0] s1_pc_o, s2_pc_o, s1_wdata_o, s2_wdata_o, s1_exc_o, s2_exc_o, hi_o, lo_o;
    logic [4:0]  s1_waddr_o, s2_waddr_o;
`ifdef EX_MEM_STALL_CNT_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] cnt_exp;
`endif

    obs_t act, exp_o;
    int   vecs = 0;
    int   miss = 0;

    always #5 clk = ~clk;

    ex_mem_dual_reg dut (
        .clk           (clk),
        .rst           (rst),
        .stall_ex      (stall_ex),
        .stall_mem     (stall_mem),
        .flush         (flush),
        .s1_valid_i    (cur.s1v),
        .s2_valid_i    (cur.s2v),
        .s1_pc_i       (cur.s1pc),
        .s2_pc_i       (cur.s2pc),
        .s1_waddr_i    (cur.s1wa),
        .s2_waddr_i    (cur.s2wa),
        .s1_we_i       (cur.s1we),
        .s2_we_i       (cur.s2we),
        .s1_wdata_i    (cur.s1wd),
        .s2_wdata_i    (cur.s2wd),
        .s1_whilo_i    (cur.s1wh),
        .s2_whilo_i    (cur.s2wh),
        .s1_hi_i       (cur.s1hi),
        .s1_lo_i       (cur.s1lo),
        .s2_hi_i       (cur.s2hi),
        .s2_lo_i       (cur.s2lo),
        .s1_exc_i      (cur.s1exc),
        .s2_exc_i      (cur.s2exc),
        .s1_valid_o    (s1_valid_o),
        .s1_pc_o       (s1_pc_o),
        .s1_waddr_o    (s1_waddr_o),
        .s1_we_o       (s1_we_o),
        .s1_wdata_o    (s1_wdata_o),
        .s1_exc_o      (s1_exc_o),
        .s2_valid_o    (s2_valid_o),
        .s2_pc_o       (s2_pc_o),
        .s2_waddr_o    (s2_waddr_o),
        .s2_we_o       (s2_we_o),
        .s2_wdata_o    (s2_wdata_o),
        .s2_exc_o      (s2_exc_o),
        .whilo_o       (whilo_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o),
        .s2_squashed_o (s2_squashed_o)
`ifdef EX_MEM_STALL_CNT_EN
        ,
        .stall_cnt_o   (stall_cnt_o)
`endif
    );

    assign act = {s1_valid_o, s1_pc_o, s1_waddr_o, s1_we_o, s1_wdata_o, s1_exc_o,
                  s2_valid_o, s2_pc_o, s2_waddr_o, s2_we_o, s2_wdata_o, s2_exc_o,
                  whilo_o, hi_o, lo_o, s2_squashed_o};

    // What a freshly loaded entry should look like, straight from the slot rules.
    function automatic obs_t load_entry(input in_t x);
        obs_t o;
        logic sq, w1, w2;
        sq = x.s1v && (x.s1exc != 0);
        o = '0;
        o.s1v = x.s1v;  o.s1pc = x.s1pc;  o.s1wa = x.s1wa;
        o.s1we = x.s1we && x.s1v;  o.s1wd = x.s1wd;  o.s1exc = x.s1exc;
        o.s2pc = x.s2pc;  o.s2wa = x.s2wa;  o.s2wd = x.s2wd;
        o.s2v   = sq ? 1'b0 : x.s2v;
        o.s2we  = sq ? 1'b0 : (x.s2we && x.s2v);
        o.s2exc = sq ? 32'h0 : x.s2exc;
        o.sq    = sq;
        w1 = x.s1wh && x.s1v;
        w2 = !sq && x.s2wh && x.s2v;
        if (w2) begin
            o.whilo = 1'b1; o.hi = x.s2hi; o.lo = x.s2lo;
        end else if (w1) begin
            o.whilo = 1'b1; o.hi = x.s1hi; o.lo = x.s1lo;
        end
        return o;
    endfunction

    function automatic in_t rand_in();
        in_t x;
        x = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom};
        x.s1v = ($urandom_range(0, 3) != 0);
        x.s2v = x.s1v && ($urandom_range(0, 3) != 0);
        x.s1exc = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
        x.s2exc = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
        if (x.s1exc[12]) x.s1we = 1'b0;
        if (x.s2exc[12]) x.s2we = 1'b0;
        return x;
    endfunction

    // One clock: advance the model with the inputs seen at the edge, settle at negedge.
    task automatic step();
        @(posedge clk);
        if (rst || flush)
            exp_o = '0;
        else if (stall_ex && !stall_mem)
            exp_o = '0;
        else if (!stall_ex)
            exp_o = load_entry(cur);
`ifdef EX_MEM_STALL_CNT_EN
        if (rst)
            cnt_exp = 0;
        else if (stall_ex && !flush && cnt_exp != 32'hFFFF_FFFF)
            cnt_exp = cnt_exp + 1;
`endif
        @(negedge clk);
    endtask

    task automatic ctl(input logic r, input logic se, input logic sm, input logic f);
        rst = r; stall_ex = se; stall_mem = sm; flush = f;
    endtask

    task automatic test_reset();
        ctl(1, 0, 0, 0);
        cur = rand_in();
        step();
        step();
        vecs++;
        if (act !== '0) begin
            miss++;
            $display("FAIL reset: got %h want 0", act);
        end
        ctl(0, 0, 0, 0);
    endtask

    task automatic test_dual_load();
        in_t x = '0;
        x.s1v = 1; x.s1we = 1; x.s1wa = 5'd3; x.s1wd = 32'h11; x.s1pc = 32'hBFC0_0000;
        x.s2v = 1; x.s2we = 1; x.s2wa = 5'd4; x.s2wd = 32'h22; x.s2pc = 32'hBFC0_0004;
        cur = x;
        step();
        vecs++;
        if ({s1_we_o, s1_waddr_o, s1_wdata_o, s2_we_o, s2_waddr_o, s2_wdata_o, s2_squashed_o}
            !== {1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0}) begin
            miss++;
            $display("FAIL dual_load: got %h want %h", act, exp_o);
        end
        vecs++;
        if (act !== exp_o) begin
            miss++;
            $display("FAIL dual_load_model: got %h want %h", act, exp_o);
        end
    endtask

    task automatic test_overflow_squash();
        in_t x = '0;
        x.s1v = 1; x.s1exc = 32'h0000_1000; x.s1wa = 5'd7; x.s1wd = 32'h77;
        x.s2v = 1; x.s2we = 1; x.s2wh = 1; x.s2hi = 32'hBEEF; x.s2wa = 5'd9; x.s2wd = 32'h99;
        cur = x;
        step();
        vecs++;
        if ({s2_we_o, s2_valid_o, whilo_o, s2_squashed_o, s1_exc_o, s2_exc_o, s2_wdata_o}
            !== {1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1000, 32'h0, 32'h99}) begin
            miss++;
            $display("FAIL ovf_squash: got we=%b v=%b whilo=%b sq=%b exc1=%h wd2=%h want 0 0 0 1 00001000 99",
                     s2_we_o, s2_valid_o, whilo_o, s2_squashed_o, s1_exc_o, s2_wdata_o);
        end
    endtask

    task automatic test_hilo_merge();
        in_t x = '0;
        x.s1v = 1; x.s1wh = 1; x.s1hi = 32'hA; x.s1lo = 32'hA0;
        x.s2v = 1; x.s2wh = 1; x.s2hi = 32'hB; x.s2lo = 32'hB0;
        cur = x;
        step();
        vecs++;
        if ({whilo_o, hi_o, lo_o} !== {1'b1, 32'hB, 32'hB0}) begin
            miss++;
            $display("FAIL hilo_s2_wins: got %b %h %h want 1 b b0", whilo_o, hi_o, lo_o);
        end
        x.s2wh = 0;
        cur = x;
        step();
        vecs++;
        if ({whilo_o, hi_o, lo_o} !== {1'b1, 32'hA, 32'hA0}) begin
            miss++;
            $display("FAIL hilo_s1: got %b %h %h want 1 a a0", whilo_o, hi_o, lo_o);
        end
        x.s1wh = 0;
        cur = x;
        step();
        vecs++;
        if ({whilo_o, hi_o, lo_o} !== 65'h0) begin
            miss++;
            $display("FAIL hilo_none: got %b %h %h want 0 0 0", whilo_o, hi_o, lo_o);
        end
    endtask

    task automatic test_stall_bubble();
        obs_t held;
        cur = rand_in();
        cur.s1v = 1; cur.s1wh = 1; cur.s1exc = 0; cur.s1we = 1;
        step();
        held = act;
        ctl(0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cur = rand_in();
            step();
            vecs++;
            if (act !== held || act !== exp_o) begin
                miss++;
                $display("FAIL stall_hold%0d: got %h want %h", i, act, held);
            end
        end
        ctl(0, 1, 0, 0);
        step();
        vecs++;
        if ({s1_valid_o, s1_we_o, s2_valid_o, s2_we_o, whilo_o} !== 5'b0 || act !== exp_o) begin
            miss++;
            $display("FAIL bubble: got %h want %h", act, exp_o);
        end
        ctl(0, 0, 0, 0);
        cur = rand_in();
        step();
        vecs++;
        if (act !== exp_o) begin
            miss++;
            $display("FAIL post_bubble_load: got %h want %h", act, exp_o);
        end
    endtask

    task automatic test_flush_over_stall();
        cur = rand_in();
        cur.s1v = 1; cur.s1pc = 32'h1234;
        step();
        ctl(0, 1, 1, 1);
        step();
        vecs++;
        if (act !== '0) begin
            miss++;
            $display("FAIL flush_over_stall: got %h want 0", act);
        end
        ctl(0, 0, 0, 0);
    endtask

    task automatic test_rst_mid_stall();
        cur = rand_in();
        cur.s1v = 1; cur.s1pc = 32'h5678;
        step();
        ctl(0, 1, 1, 0);
        step();
        ctl(1, 1, 1, 0);
        step();
        vecs++;
        if (act !== '0) begin
            miss++;
            $display("FAIL rst_mid_stall: got %h want 0", act);
        end
        ctl(0, 1, 1, 0);
        step();
        vecs++;
        if (act !== '0) begin
            miss++;
            $display("FAIL rst_no_held_state: got %h want 0", act);
        end
        ctl(0, 0, 0, 0);
    endtask

`ifdef EX_MEM_STALL_CNT_EN
    task automatic test_stall_cnt();
        ctl(1, 0, 0, 0);
        step();
        vecs++;
        if (stall_cnt_o !== 32'd0) begin
            miss++;
            $display("FAIL stall_cnt_reset: got %0d want 0", stall_cnt_o);
        end
        for (int i = 0; i < 5; i++) begin
            ctl(0, 1, (i % 2) == 0, i == 2);
            step();
        end
        ctl(0, 0, 0, 0);
        vecs++;
        if (stall_cnt_o !== 32'd4) begin
            miss++;
            $display("FAIL stall_cnt_flush: got %0d want 4", stall_cnt_o);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            ctl($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 1) == 0, $urandom_range(0, 19) == 0);
            cur = rand_in();
            step();
            vecs++;
            if (act !== exp_o) begin
                miss++;
                $display("FAIL random%0d: got %h want %h", i, act, exp_o);
            end
`ifdef EX_MEM_STALL_CNT_EN
            vecs++;
            if (stall_cnt_o !== cnt_exp) begin
                miss++;
                $display("FAIL random_cnt%0d: got %0d want %0d", i, stall_cnt_o, cnt_exp);
            end
`endif
        end
        ctl(0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_o = '0;
`ifdef EX_MEM_STALL_CNT_EN
        cnt_exp = 0;
`endif
        ctl(1, 0, 0, 0);
        cur = '0;
        @(negedge clk);
        test_reset();
        test_dual_load();
        test_overflow_squash();
        test_hilo_merge();
        test_stall_bubble();
        test_flush_over_stall();
        test_rst_mid_stall();
`ifdef EX_MEM_STALL_CNT_EN
        test_stall_cnt();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/ex_mem_dual_reg.md
Name: ex_mem_dual_reg

Overview:
- EX→MEM pipeline register for the dual-issue core.
- Captures both execute sub-units' results each cycle: write address/enable/data, HI/LO write and exception vector per slot, plus slot PC and valid.
- Enforces precise exceptions across slots: a slot-1 exception squashes slot 2's architectural writes.
- Handles stall, bubble insertion and flush.
- Feeds the MEM stage and the HI/LO register file.

Parameters:
- DATA_W, 32, data/HI/LO word width
- ADDR_W, 5, register-file address width
- EXC_W, 32, exception-type vector width; bit 12 = overflow

Ports:
- clk  in  1  clock
- rst  in  1  reset
- stall_ex  in  1  EX stage held
- stall_mem  in  1  MEM stage held
- flush  in  1  exception/eret flush
- s1_valid_i, s2_valid_i  in  1 each  slot issued valid
- s1_pc_i, s2_pc_i  in  32 each  slot PC
- s1_waddr_i, s2_waddr_i  in  ADDR_W each  destination register
- s1_we_i, s2_we_i  in  1 each  GPR write enable
- s1_wdata_i, s2_wdata_i  in  DATA_W each  GPR write data
- s1_whilo_i, s2_whilo_i  in  1 each  HI/LO write enable
- s1_hi_i, s1_lo_i, s2_hi_i, s2_lo_i  in  DATA_W each  HI/LO write values
- s1_exc_i, s2_exc_i  in  EXC_W each  exception vector
- s1_*_o, s2_*_o  out  same widths  registered copies of valid/pc/waddr/we/wdata/exc
- whilo_o  out  1  merged HI/LO write enable
- hi_o, lo_o  out  DATA_W each  merged HI/LO value
- s2_squashed_o  out  1  slot 2 killed by slot-1 exception this entry

Behaviour:
- Reset: reset rst, synchronous, active-high. All outputs 0 (valid 0, we 0, whilo 0, data/pc/exc 0); applies regardless of stall or flush.
- Update priority at posedge, highest first:
  1. rst
  2. flush → clear all as reset
  3. stall_ex && !stall_mem → load bubble (all fields 0)
  4. stall_ex && stall_mem → hold
  5. !stall_ex → load new entry
- Latency: one cycle, input to output.
- Slot 1 loaded as presented. s1_we_o = s1_we_i & s1_valid_i; whilo contribution is gated the same way.
- Squash condition: s1_valid_i && |s1_exc_i.
  - On squash: slot 2 loads with valid=0, we=0, whilo=0, exc=0, and s2_squashed_o=1.
  - pc/waddr/wdata still captured for debug.
- Slot 2 with no squash: s2_we_o = s2_we_i & s2_valid_i.
- HI/LO merge, on the gated whilo of each slot:
  - Slot 2 wins when it writes (later in program order): whilo_o=1, hi_o/lo_o from slot 2.
  - Otherwise slot 1 if it writes.
  - Otherwise whilo_o=0, hi_o=lo_o=0.
- Overflow case: the upstream sub-unit has already deasserted we for an overflowing add/sub. The register does not re-derive it; it propagates exc bit 12.
- Slot 2 valid without slot 1 valid is illegal; assert in simulation. RTL loads slot 2 normally.
- flush together with stall_ex → flush wins.
- rst mid-stall → cleared; no held state survives.

Optional Feature:
- Macro EX_MEM_STALL_CNT_EN.
- Defined: adds a 32-bit output stall_cnt_o, reset to 0.
  - Increments each cycle that stall_ex && !flush.
  - Saturates at 0xFFFFFFFF.
  - Cleared only by rst.
- Undefined: port and counter absent; no other behaviour changes.

Decomposition:
- Shared defines package holds: RstEnable, ZeroWord, WriteEnable/WriteDisable, OverflowAssert, the overflow bit index (12), RegBus/RegAddrBus widths.
- One natural sub-module, ex_mem_slot_reg: a single-slot register with load/bubble/hold/clear and a kill input. Instantiated twice; slot 2's kill is the squash condition.
- HI/LO merge and squash logic live in the top.

Test Plan:
- Dual load: s1 (we=1, waddr=3, wdata=0x11), s2 (we=1, waddr=4, wdata=0x22), no stall → next cycle both outputs match, s2_squashed_o=0.
- Slot-1 overflow: s1_exc=0x00001000, s2 we=1, whilo=1 → s2_we_o=0, whilo_o=0, s2_squashed_o=1, s1_exc_o=0x00001000.
- HI/LO merge: s1 whilo hi=0xA, s2 whilo hi=0xB → hi_o=0xB. Then s2 whilo=0 → hi_o=0xA.
- Stall then bubble:
  - stall_ex=1, stall_mem=1 for 3 cycles → outputs held.
  - Then stall_mem=0 → valid/we/whilo all 0.
  - Then stall_ex=0 → new entry loads.
- Flush over stall: flush=1 with stall_ex=1 and stale entry → all outputs 0 next cycle. rst asserted mid-stall → same.
- EX_MEM_STALL_CNT_EN defined: 5 stall_ex cycles with 1 flush cycle among them → stall_cnt_o=4.
